// File: rtl/framebuffer_writer.sv
// framebuffer_writer: SRAM write-side master for a double-buffered framebuffer.
// Accepts FILL-rectangle and SWAP commands over a valid/ready handshake.
// FILL writes one pixel per SRAM transaction into the back buffer. SWAP
// exchanges the front and back bases on the next rising edge of paintDone.
// Optional feature: define FB_CLIP_EN to clip FILL rectangles to the visible area.

package framebuffer_writer_pkg;
  typedef logic [15:0] Pixel_t;
  typedef logic [19:0] SramAddress_t;

  typedef struct packed {
    SramAddress_t address;
    Pixel_t       data;
    logic         we_n;
    logic         oe_n;
    logic         den;
  } SramRequest_t;

  typedef struct packed {
    logic done;
  } SramResult_t;
endpackage

module framebuffer_writer
  import framebuffer_writer_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned BUF0_BASE = 0,
  parameter int unsigned BUF1_BASE = H_ACTIVE * V_ACTIVE
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmdValid,
  output logic         cmdReady,
  input  logic [1:0]   cmdOp,
  input  logic [9:0]   cmdX,
  input  logic [8:0]   cmdY,
  input  logic [9:0]   cmdW,
  input  logic [8:0]   cmdH,
  input  Pixel_t       cmdColor,
  input  logic         paintDone,
  input  SramResult_t  ramResult,
  output SramRequest_t ramRequest,
  output SramAddress_t displayBase,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    SWAP_WAIT,
    DONE
  } state_t;

  state_t       state;
  state_t       stateNext;

  logic [9:0]   x0;
  logic [8:0]   y0;
  logic [9:0]   wReg;
  logic [8:0]   hReg;
  logic [9:0]   colIdx;
  logic [8:0]   rowIdx;
  logic [9:0]   colNext;
  logic [8:0]   rowNext;
  Pixel_t       colorReg;
  SramAddress_t backBase;
  logic         paintPrev;

  logic         accept;
  logic         paintRise;
  logic         fillLast;
  logic [9:0]   effW;
  logic [8:0]   effH;
  logic         emptyRect;

  // Linear pixel address, computed at SRAM address width with truncation.
  function automatic SramAddress_t pixelAddr(input SramAddress_t base,
                                             input SramAddress_t y,
                                             input SramAddress_t x);
    return base + y * SramAddress_t'(H_ACTIVE) + x;
  endfunction

  assign accept    = cmdValid && (state == IDLE);
  assign paintRise = paintDone && !paintPrev;
  assign fillLast  = (colIdx == wReg - 10'd1) && (rowIdx == hReg - 9'd1);

`ifdef FB_CLIP_EN
  // Clip the incoming rectangle to the visible area; empty results skip to DONE.
  always_comb begin
    effW      = cmdW;
    effH      = cmdH;
    emptyRect = 1'b0;
    if ((32'(cmdX) >= H_ACTIVE) || (32'(cmdY) >= V_ACTIVE)) begin
      emptyRect = 1'b1;
    end else begin
      if (32'(cmdW) > H_ACTIVE - 32'(cmdX)) effW = 10'(H_ACTIVE - 32'(cmdX));
      if (32'(cmdH) > V_ACTIVE - 32'(cmdY)) effH = 9'(V_ACTIVE - 32'(cmdY));
      if ((effW == '0) || (effH == '0)) emptyRect = 1'b1;
    end
  end
`else
  // Rectangle is used as given; only a zero dimension suppresses writes.
  always_comb begin
    effW      = cmdW;
    effH      = cmdH;
    emptyRect = (cmdW == '0) || (cmdH == '0);
  end
`endif

  // Raster-order step: column first, wrapping to the next row at the right edge.
  always_comb begin
    colNext = colIdx + 10'd1;
    rowNext = rowIdx;
    if (colIdx == wReg - 10'd1) begin
      colNext = '0;
      rowNext = rowIdx + 9'd1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // Next-state decode.
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: begin
        if (cmdValid) begin
          unique case (cmdOp)
            2'b00:   stateNext = emptyRect ? DONE : FILL;
            2'b01:   stateNext = SWAP_WAIT;
            default: stateNext = DONE;
          endcase
        end
      end
      FILL:      if (ramResult.done && fillLast) stateNext = DONE;
      SWAP_WAIT: if (paintRise) stateNext = DONE;
      DONE:      stateNext = IDLE;
      default:   stateNext = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from state.
  always_comb begin
    cmdReady = (state == IDLE);
    busy     = (state != IDLE);
  end

  // paintDone history for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) paintPrev <= 1'b0;
    else     paintPrev <= paintDone;
  end

  // Command latch, pixel walk, registered SRAM request and buffer bases.
  // The first pixel's request is loaded on the accepting edge and each
  // following pixel on the completing edge, so writes run back to back.
  always_ff @(posedge clk) begin
    if (rst) begin
      x0                 <= '0;
      y0                 <= '0;
      wReg               <= '0;
      hReg               <= '0;
      colIdx             <= '0;
      rowIdx             <= '0;
      colorReg           <= '0;
      backBase           <= SramAddress_t'(BUF1_BASE);
      displayBase        <= SramAddress_t'(BUF0_BASE);
      ramRequest.address <= '0;
      ramRequest.data    <= '0;
      ramRequest.we_n    <= 1'b1;
      ramRequest.oe_n    <= 1'b1;
      ramRequest.den     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            x0       <= cmdX;
            y0       <= cmdY;
            wReg     <= effW;
            hReg     <= effH;
            colIdx   <= '0;
            rowIdx   <= '0;
            colorReg <= cmdColor;
            if ((cmdOp == 2'b00) && !emptyRect) begin
              ramRequest.address <= pixelAddr(backBase, SramAddress_t'(cmdY),
                                              SramAddress_t'(cmdX));
              ramRequest.data    <= cmdColor;
              ramRequest.we_n    <= 1'b0;
              ramRequest.den     <= 1'b1;
            end
          end
        end
        FILL: begin
          if (ramResult.done) begin
            if (fillLast) begin
              ramRequest.we_n <= 1'b1;
              ramRequest.den  <= 1'b0;
            end else begin
              colIdx             <= colNext;
              rowIdx             <= rowNext;
              ramRequest.address <= pixelAddr(backBase,
                                              SramAddress_t'(y0) + SramAddress_t'(rowNext),
                                              SramAddress_t'(x0) + SramAddress_t'(colNext));
              ramRequest.data    <= colorReg;
            end
          end
        end
        SWAP_WAIT: begin
          if (paintRise) begin
            displayBase <= backBase;
            backBase    <= displayBase;
          end
        end
        DONE: begin
          ramRequest.we_n <= 1'b1;
          ramRequest.den  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_framebuffer_writer.sv
// Self-checking bench for framebuffer_writer: table of FILL/no-op commands
// with done tied high, plus hand sequences for stalls, SWAP and mid-fill reset.

module tb_framebuffer_writer;
  import framebuffer_writer_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmdValid = 1'b0;
  logic         cmdReady;
  logic [1:0]   cmdOp = '0;
  logic [9:0]   cmdX = '0;
  logic [8:0]   cmdY = '0;
  logic [9:0]   cmdW = '0;
  logic [8:0]   cmdH = '0;
  Pixel_t       cmdColor = '0;
  logic         paintDone = 1'b0;
  logic         doneDrv = 1'b1;
  SramResult_t  ramResult;
  SramRequest_t ramRequest;
  SramAddress_t displayBase;
  logic         busy;

  assign ramResult = SramResult_t'(doneDrv);

  framebuffer_writer dut (
    .clk        (clk),
    .rst        (rst),
    .cmdValid   (cmdValid),
    .cmdReady   (cmdReady),
    .cmdOp      (cmdOp),
    .cmdX       (cmdX),
    .cmdY       (cmdY),
    .cmdW       (cmdW),
    .cmdH       (cmdH),
    .cmdColor   (cmdColor),
    .paintDone  (paintDone),
    .ramResult  (ramResult),
    .ramRequest (ramRequest),
    .displayBase(displayBase),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Write log: a write completes on the edge after a cycle with we_n=0 and done=1.
  SramAddress_t wrAddr[$];
  Pixel_t       wrData[$];
  int           oeBad = 0;

  always @(negedge clk) begin
    if (ramRequest.oe_n !== 1'b1) oeBad++;
    if (!rst && ramRequest.we_n === 1'b0 && ramResult.done === 1'b1) begin
      wrAddr.push_back(ramRequest.address);
      wrData.push_back(ramRequest.data);
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic acceptCmd(input logic [1:0] op, input logic [9:0] x, input logic [8:0] y,
                           input logic [9:0] w, input logic [8:0] h, input Pixel_t color);
    int waitCnt = 0;
    while (!cmdReady && waitCnt < 100) begin
      step();
      waitCnt++;
    end
    check("ready_before_cmd", longint'(cmdReady), 1);
    cmdOp    = op;
    cmdX     = x;
    cmdY     = y;
    cmdW     = w;
    cmdH     = h;
    cmdColor = color;
    cmdValid = 1'b1;
    step();
    cmdValid = 1'b0;
  endtask

  // Samples with cmdReady low, starting right after the accepting edge.
  task automatic countLow(output int lowCnt);
    lowCnt = 0;
    while (!cmdReady && lowCnt < 300) begin
      lowCnt++;
      step();
    end
  endtask

  typedef struct {
    logic [1:0] op;
    logic [9:0] x;
    logic [8:0] y;
    logic [9:0] w;
    logic [8:0] h;
    Pixel_t     color;
    int         nWr;
    int         first;
    int         last;
    int         sum;
    int         readyLow;
  } Vec_t;

  Vec_t vec[7];

  initial begin
    int lowCnt;
    int start;
    int n;
    int badData;
    longint sum;
    SramAddress_t order[6];

    vec[0] = '{2'b00, 10'd2,   9'd1,   10'd3, 9'd2, 16'hABCD, 6, 307842, 308484, 1848978, 7};
    vec[1] = '{2'b00, 10'd4,   9'd4,   10'd0, 9'd5, 16'h1111, 0, 0, 0, 0, 1};
    vec[2] = '{2'b11, 10'd1,   9'd1,   10'd2, 9'd2, 16'h2222, 0, 0, 0, 0, 1};
    vec[3] = '{2'b00, 10'd0,   9'd0,   10'd1, 9'd1, 16'h1234, 1, 307200, 307200, 307200, 2};
`ifdef FB_CLIP_EN
    vec[4] = '{2'b00, 10'd638, 9'd479, 10'd5, 9'd3, 16'h5A5A, 2, 614398, 614399, 1228797, 3};
    vec[5] = '{2'b00, 10'd700, 9'd0,   10'd2, 9'd1, 16'h3333, 0, 0, 0, 0, 1};
`else
    vec[4] = '{2'b00, 10'd638, 9'd479, 10'd5, 9'd3, 16'h5A5A, 15, 614398, 615682, 9225600, 16};
    vec[5] = '{2'b00, 10'd700, 9'd0,   10'd2, 9'd1, 16'h3333, 2, 307900, 307901, 615801, 3};
`endif
    vec[6] = '{2'b00, 10'd10,  9'd0,   10'd4, 9'd1, 16'h4444, 4, 307210, 307213, 1228846, 5};

    order[0] = 20'd307842; order[1] = 20'd307843; order[2] = 20'd307844;
    order[3] = 20'd308482; order[4] = 20'd308483; order[5] = 20'd308484;

    // Reset state.
    rst = 1'b1;
    step(); step(); step();
    check("rst_cmdReady", longint'(cmdReady), 1);
    check("rst_busy", longint'(busy), 0);
    check("rst_we_n", longint'(ramRequest.we_n), 1);
    check("rst_oe_n", longint'(ramRequest.oe_n), 1);
    check("rst_den", longint'(ramRequest.den), 0);
    check("rst_address", longint'(ramRequest.address), 0);
    check("rst_data", longint'(ramRequest.data), 0);
    check("rst_displayBase", longint'(displayBase), 0);
    rst = 1'b0;
    step();

    // Table-driven commands with done tied high.
    doneDrv = 1'b1;
    for (int i = 0; i < 7; i++) begin
      start = wrAddr.size();
      acceptCmd(vec[i].op, vec[i].x, vec[i].y, vec[i].w, vec[i].h, vec[i].color);
      check($sformatf("v%0d_busy", i), longint'(busy), 1);
      countLow(lowCnt);
      step();
      n = wrAddr.size() - start;
      check($sformatf("v%0d_writes", i), n, vec[i].nWr);
      check($sformatf("v%0d_readyLow", i), lowCnt, vec[i].readyLow);
      sum = 0;
      badData = 0;
      for (int k = start; k < wrAddr.size(); k++) begin
        sum += longint'(wrAddr[k]);
        if (wrData[k] != vec[i].color) badData++;
      end
      check($sformatf("v%0d_addrSum", i), sum, vec[i].sum);
      check($sformatf("v%0d_badData", i), badData, 0);
      if (vec[i].nWr > 0 && n > 0) begin
        check($sformatf("v%0d_first", i), longint'(wrAddr[start]), vec[i].first);
        check($sformatf("v%0d_last", i), longint'(wrAddr[wrAddr.size() - 1]), vec[i].last);
      end
    end

    // Exact write order of the first rectangle.
    for (int k = 0; k < 6; k++) begin
      if (k < wrAddr.size()) check($sformatf("order_%0d", k), longint'(wrAddr[k]), longint'(order[k]));
      else check($sformatf("order_%0d_missing", k), 0, 1);
    end

    // Single pixel with done only every third cycle: request must hold steady.
    doneDrv = 1'b0;
    start = wrAddr.size();
    acceptCmd(2'b00, 10'd5, 9'd5, 10'd1, 9'd1, 16'h0F0F);
    for (int k = 0; k < 2; k++) begin
      check("stall_we_n", longint'(ramRequest.we_n), 0);
      check("stall_den", longint'(ramRequest.den), 1);
      check("stall_addr", longint'(ramRequest.address), 310405);
      check("stall_data", longint'(ramRequest.data), 16'h0F0F);
      step();
    end
    check("stall_addr_final", longint'(ramRequest.address), 310405);
    doneDrv = 1'b1;
    step();
    doneDrv = 1'b0;
    check("stall_we_n_after", longint'(ramRequest.we_n), 1);
    step(); step(); step();
    check("stall_writes", wrAddr.size() - start, 1);
    doneDrv = 1'b1;

    // SWAP issued while paintDone is already high waits for a fresh rising edge.
    paintDone = 1'b1;
    step(); step();
    acceptCmd(2'b01, '0, '0, '0, '0, '0);
    step(); step(); step();
    check("swap_wait_base", longint'(displayBase), 0);
    check("swap_wait_busy", longint'(busy), 1);
    check("swap_wait_we_n", longint'(ramRequest.we_n), 1);
    paintDone = 1'b0;
    step(); step();
    check("swap_low_base", longint'(displayBase), 0);
    paintDone = 1'b1;
    step();
    check("swap_edge_base", longint'(displayBase), 307200);
    check("swap_done_ready", longint'(cmdReady), 0);
    paintDone = 1'b0;
    start = wrAddr.size();
    acceptCmd(2'b00, 10'd0, 9'd0, 10'd1, 9'd1, 16'h0A0A);
    countLow(lowCnt);
    step();
    check("swap_fill_writes", wrAddr.size() - start, 1);
    if (wrAddr.size() > start) check("swap_fill_addr", longint'(wrAddr[start]), 0);

    // Reset during the third pixel of a ten-pixel FILL (back buffer is now BUF0).
    start = wrAddr.size();
    acceptCmd(2'b00, 10'd0, 9'd0, 10'd10, 9'd1, 16'h7777);
    step(); step();
    check("mid_pixel2_addr", longint'(ramRequest.address), 2);
    rst = 1'b1;
    step();
    check("mid_rst_we_n", longint'(ramRequest.we_n), 1);
    check("mid_rst_den", longint'(ramRequest.den), 0);
    check("mid_rst_ready", longint'(cmdReady), 1);
    check("mid_rst_busy", longint'(busy), 0);
    check("mid_rst_base", longint'(displayBase), 0);
    rst = 1'b0;
    step(); step(); step(); step(); step();
    check("mid_rst_writes", wrAddr.size() - start, 2);
    check("mid_rst_we_n_later", longint'(ramRequest.we_n), 1);
    start = wrAddr.size();
    acceptCmd(2'b00, 10'd0, 9'd0, 10'd1, 9'd1, 16'h0B0B);
    countLow(lowCnt);
    step();
    check("post_rst_writes", wrAddr.size() - start, 1);
    if (wrAddr.size() > start) check("post_rst_addr", longint'(wrAddr[start]), 307200);

    check("oe_n_always_high", oeBad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
